// File: rtl/if_id_fetch_ctrl_if.sv
// +----------------------------------------------------------------------+
// | Module   : if_id_fetch_ctrl_if                                       |
// | Brief    : Fetch-control bundle: hazard handshake, redirect, imem,   |
// |            IF/ID register outputs and debug counters.                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

interface if_id_fetch_ctrl_if;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        Hazard;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] IF_ID_inst;
  logic [31:0] IF_ID_pc;
  logic        IF_ID_valid;
  logic        halted;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  modport master (
    input  PCWrite, IF_ID_Write, Hazard, redirect_valid, redirect_pc,
           halt_req, imem_rdata,
    output imem_addr, pc, IF_ID_inst, IF_ID_pc, IF_ID_valid, halted,
           stall_count, flush_count
  );

  modport slave (
    output PCWrite, IF_ID_Write, Hazard, redirect_valid, redirect_pc,
           halt_req, imem_rdata,
    input  imem_addr, pc, IF_ID_inst, IF_ID_pc, IF_ID_valid, halted,
           stall_count, flush_count
  );
endinterface

`default_nettype wire

// File: rtl/if_id_fetch_ctrl.sv
// +----------------------------------------------------------------------+
// | Module   : if_id_fetch_ctrl                                          |
// | Brief    : PC and IF/ID register owner honouring stall, redirect and |
// |            halt requests, with stall/flush event counters.           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module if_id_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  wire                  clk,
  input  wire                  reset,
  if_id_fetch_ctrl_if.master   bus
);

  localparam logic [31:0] c_PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_inst, w_inst_next;
  logic [31:0] r_if_pc, w_if_pc_next;
  logic        r_valid, w_valid_next;
  logic [31:0] r_stall_count, w_stall_count_next;
  logic [31:0] r_flush_count, w_flush_count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_inst        <= NOP_INST;
      r_if_pc       <= RESET_PC;
      r_valid       <= 1'b0;
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_inst        <= w_inst_next;
      r_if_pc       <= w_if_pc_next;
      r_valid       <= w_valid_next;
      r_stall_count <= w_stall_count_next;
      r_flush_count <= w_flush_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_inst_next        = r_inst;
    w_if_pc_next       = r_if_pc;
    w_valid_next       = r_valid;
    w_stall_count_next = r_stall_count;
    w_flush_count_next = r_flush_count;

    case (r_state)
      S_BOOT: begin
        // First fetch is unconditional; stall inputs are not yet meaningful.
        w_pc_next    = r_pc + c_PC_STEP;
        w_inst_next  = bus.imem_rdata;
        w_if_pc_next = r_pc;
        w_valid_next = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (bus.Hazard) begin
          w_stall_count_next = r_stall_count + 32'd1;
        end
        if (bus.halt_req) begin
          w_inst_next  = NOP_INST;
          w_if_pc_next = r_pc;
          w_valid_next = 1'b0;
          w_state_next = S_HALTED;
        end else if (bus.redirect_valid) begin
          // Redirect wins over both stall enables.
          w_pc_next          = bus.redirect_pc;
          w_inst_next        = NOP_INST;
          w_if_pc_next       = r_pc;
          w_valid_next       = 1'b0;
          w_flush_count_next = r_flush_count + 32'd1;
        end else begin
          if (bus.PCWrite) begin
            w_pc_next = r_pc + c_PC_STEP;
          end
          if (bus.IF_ID_Write) begin
            w_inst_next  = bus.imem_rdata;
            w_if_pc_next = r_pc;
            w_valid_next = 1'b1;
          end
        end
      end
      S_HALTED: begin
        w_state_next = S_HALTED;
      end
      default: begin
        w_state_next = S_BOOT;
      end
    endcase
  end

  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.IF_ID_inst  = r_inst;
  assign bus.IF_ID_pc    = r_if_pc;
  assign bus.IF_ID_valid = r_valid;
  assign bus.halted      = (r_state == S_HALTED);
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;

endmodule

`default_nettype wire
